paddle_input_scheduler: RTL and testbench

Converts the raw PS/2 scan-code byte stream from PS2_Controller into a held-key bitmap for the four paddle keys. On every game frame tick it issues one registered move command per paddle to the Pong game logic. It replaces one-shot "last key" decoding with true make/break hold tracking, including E0-extended arrows. A frame-based watchdog clears stuck keys if the keyboard falls silent.

---
 rtl/pong_input_pkg.sv | 71 +++++++
 rtl/ps2_scan_parser.sv | 97 +++++++++
 rtl/paddle_input_scheduler.sv | 112 +++++++++++
 tb/tb_paddle_input_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_input_pkg.sv
// Shared definitions for the paddle keyboard input path.
//   - PS/2 set-2 scan-code constants for the four paddle keys, the two
//     extended arrow keys and the E0/F0 prefix bytes
//   - paddle move encoding
//   - bit positions of each key in the held-key bitmap
//   - scan-code lookup and move-direction helpers
package pong_input_pkg;

    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_O    = 8'h44;
    localparam logic [7:0] SC_K    = 8'h42;
    localparam logic [7:0] SC_UP   = 8'h75;  // only meaningful after E0
    localparam logic [7:0] SC_DOWN = 8'h72;  // only meaningful after E0
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;

    typedef enum logic [1:0] {
        MOVE_NONE = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10
    } move_e;

    localparam logic [1:0] KEY_W = 2'd0;
    localparam logic [1:0] KEY_S = 2'd1;
    localparam logic [1:0] KEY_O = 2'd2;  // O and Up arrow share this bit
    localparam logic [1:0] KEY_K = 2'd3;  // K and Down arrow share this bit

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } parse_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_lookup_t;

    // Maps a final scan byte (with its extended flag) to a bitmap index.
    function automatic key_lookup_t lookup_key(input logic [7:0] code, input logic ext);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = KEY_W;
        if (!ext) begin
            case (code)
                SC_W:    r.idx = KEY_W;
                SC_S:    r.idx = KEY_S;
                SC_O:    r.idx = KEY_O;
                SC_K:    r.idx = KEY_K;
                default: r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:   r.idx = KEY_O;
                SC_DOWN: r.idx = KEY_K;
                default: r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Opposing keys cancel: both or neither held means no movement.
    function automatic move_e move_from(input logic up, input logic down);
        if (up && !down) return MOVE_UP;
        if (down && !up) return MOVE_DOWN;
        return MOVE_NONE;
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// PS/2 make/break prefix parser.
//   inclock, resetn : clock, asynchronous active-low reset
//   scan_code       : received byte, qualified by scan_valid
//   flush           : forces the parser back to IDLE (watchdog timeout)
//   key_evt         : pulse, a mapped key was made or broken this cycle
//   key_idx         : bitmap index of that key
//   key_make        : 1 = make (press), 0 = break (release)
//   parse_err       : pulse, a prefix byte arrived where it is not legal
// Event outputs are decoded combinationally from the completing byte so the
// bitmap register in the top can update on the very next edge.
module ps2_scan_parser
    import pong_input_pkg::*;
(
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       flush,
    output logic       key_evt,
    output logic [1:0] key_idx,
    output logic       key_make,
    output logic       parse_err
);

    parse_state_e state_q, state_d;
    key_lookup_t  lk_plain, lk_ext;
    logic         is_prefix;

    assign lk_plain  = lookup_key(scan_code, 1'b0);
    assign lk_ext    = lookup_key(scan_code, 1'b1);
    assign is_prefix = (scan_code == SC_EXT) || (scan_code == SC_BRK);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        key_evt   = 1'b0;
        key_idx   = KEY_W;
        key_make  = 1'b0;
        parse_err = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                PS_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_d = PS_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_d = PS_BRK;
                    end else begin
                        key_evt  = lk_plain.hit;
                        key_idx  = lk_plain.idx;
                        key_make = 1'b1;
                    end
                end
                PS_EXT: begin
                    if (scan_code == SC_BRK) begin
                        state_d = PS_EXT_BRK;
                    end else if (scan_code == SC_EXT) begin
                        parse_err = 1'b1;  // repeated E0: stay extended
                    end else begin
                        state_d  = PS_IDLE;
                        key_evt  = lk_ext.hit;
                        key_idx  = lk_ext.idx;
                        key_make = 1'b1;
                    end
                end
                PS_BRK: begin
                    state_d = PS_IDLE;
                    if (is_prefix) begin
                        parse_err = 1'b1;
                    end else begin
                        key_evt = lk_plain.hit;
                        key_idx = lk_plain.idx;
                    end
                end
                PS_EXT_BRK: begin
                    state_d = PS_IDLE;
                    if (is_prefix) begin
                        parse_err = 1'b1;
                    end else begin
                        key_evt = lk_ext.hit;
                        key_idx = lk_ext.idx;
                    end
                end
                default: state_d = PS_IDLE;
            endcase
        end
        if (flush) state_d = PS_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) state_q <= PS_IDLE;
        else         state_q <= state_d;
    end

endmodule

// File: rtl/paddle_input_scheduler.sv
// Paddle input scheduler: PS/2 bytes -> held-key bitmap -> per-frame moves.
//   inclock, resetn : clock, asynchronous active-low reset
//   scan_code/valid : byte stream from the PS/2 receiver
//   frame_tick      : one-cycle pulse per video frame
//   key_held        : {K/Down, O/Up, S, W}
//   p1_move/p2_move : left/right paddle move (00 none, 01 up, 10 down)
//   move_valid      : pulse, moves refreshed this cycle
//   parse_err       : pulse, malformed prefix sequence seen
// A watchdog counts frames with no incoming byte and force-releases all keys
// after TIMEOUT_FRAMES of silence (0 disables it).
module paddle_input_scheduler
    import pong_input_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 120,
    parameter int CNT_W          = 8
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       frame_tick,
    output logic [3:0] key_held,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       move_valid,
    output logic       parse_err
);

    localparam logic [CNT_W:0]   TIMEOUT_W = (CNT_W + 1)'(TIMEOUT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             key_evt, key_make, perr_evt, wd_clear;
    logic [1:0]       key_idx;
    logic [3:0]       key_held_q, key_held_d;
    move_e            p1_move_q, p1_move_d, p2_move_q, p2_move_d;
    logic             move_valid_q, move_valid_d;
    logic             parse_err_q, parse_err_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [CNT_W:0]   wd_next;

    ps2_scan_parser u_parser (
        .inclock   (inclock),
        .resetn    (resetn),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .flush     (wd_clear),
        .key_evt   (key_evt),
        .key_idx   (key_idx),
        .key_make  (key_make),
        .parse_err (perr_evt)
    );

    // Watchdog: any byte restarts the silence count; a timeout only fires on
    // a tick without a byte, so it never collides with a key event.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_clear = 1'b0;
        wd_next  = {1'b0, wd_cnt_q} + (CNT_W + 1)'(1);
        if (scan_valid) begin
            wd_cnt_d = '0;
        end else if (frame_tick && (TIMEOUT_FRAMES > 0)) begin
            if (wd_next >= TIMEOUT_W) begin
                wd_clear = 1'b1;
                wd_cnt_d = '0;
            end else if (wd_cnt_q != CNT_MAX) begin
                wd_cnt_d = wd_next[CNT_W-1:0];
            end
        end
    end

    // Moves sample the registered bitmap, so a byte or timeout landing on
    // the tick cycle only affects the following frame.
    always_comb begin
        key_held_d = key_held_q;
        if (key_evt)  key_held_d[key_idx] = key_make;
        if (wd_clear) key_held_d = '0;

        p1_move_d = p1_move_q;
        p2_move_d = p2_move_q;
        if (frame_tick) begin
            p1_move_d = move_from(key_held_q[KEY_W], key_held_q[KEY_S]);
            p2_move_d = move_from(key_held_q[KEY_O], key_held_q[KEY_K]);
        end
        move_valid_d = frame_tick;
        parse_err_d  = perr_evt;
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            key_held_q   <= '0;
            p1_move_q    <= MOVE_NONE;
            p2_move_q    <= MOVE_NONE;
            move_valid_q <= 1'b0;
            parse_err_q  <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            key_held_q   <= key_held_d;
            p1_move_q    <= p1_move_d;
            p2_move_q    <= p2_move_d;
            move_valid_q <= move_valid_d;
            parse_err_q  <= parse_err_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign key_held   = key_held_q;
    assign p1_move    = p1_move_q;
    assign p2_move    = p2_move_q;
    assign move_valid = move_valid_q;
    assign parse_err  = parse_err_q;

endmodule

// File: tb/tb_paddle_input_scheduler.sv
// Self-checking bench for paddle_input_scheduler (watchdog timeout of 3
// frames). Directed scenarios followed by random byte/tick traffic, all
// compared against a reference model that interprets each completed scan
// code from its pending prefix bytes.
module tb_paddle_input_scheduler;

    localparam int TIMEOUT = 3;

    logic       inclock = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] key_held;
    logic [1:0] p1_move, p2_move;
    logic       move_valid, parse_err;

    int n_total = 0;
    int n_pass  = 0;

    paddle_input_scheduler #(
        .TIMEOUT_FRAMES(TIMEOUT),
        .CNT_W         (8)
    ) dut (
        .inclock   (inclock),
        .resetn    (resetn),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_tick(frame_tick),
        .key_held  (key_held),
        .p1_move   (p1_move),
        .p2_move   (p2_move),
        .move_valid(move_valid),
        .parse_err (parse_err)
    );

    always #5 inclock = ~inclock;

    // ---------------- reference model ----------------
    bit         m_held[4];   // W, S, O/Up, K/Down
    logic [7:0] m_pfx[$];    // prefix bytes received for the code in progress
    int         m_idle;      // frames since last byte
    logic [1:0] m_p1, m_p2;
    logic       m_mv, m_perr;

    function automatic int key_of(logic [7:0] code, bit ext);
        if (!ext && code == 8'h1D) return 0;
        if (!ext && code == 8'h1B) return 1;
        if (!ext && code == 8'h44) return 2;
        if (!ext && code == 8'h42) return 3;
        if (ext && code == 8'h75)  return 2;
        if (ext && code == 8'h72)  return 3;
        return -1;
    endfunction

    function automatic logic [1:0] dir(bit up, bit down);
        if (up == down) return 2'b00;
        return up ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [3:0] m_bitmap();
        return {m_held[3], m_held[2], m_held[1], m_held[0]};
    endfunction

    task automatic model_reset();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_pfx.delete();
        m_idle = 0;
        m_p1 = 2'b00; m_p2 = 2'b00; m_mv = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_step(logic sv, logic [7:0] code, logic tick);
        bit ext, brk;
        int k;
        m_mv   = tick;
        m_perr = 1'b0;
        if (tick) begin
            m_p1 = dir(m_held[0], m_held[1]);
            m_p2 = dir(m_held[2], m_held[3]);
        end
        if (sv) begin
            m_idle = 0;
            if (code == 8'hE0 || code == 8'hF0) begin
                if (m_pfx.size() == 0) begin
                    m_pfx.push_back(code);
                end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hE0) begin
                    if (code == 8'hF0) m_pfx.push_back(code);
                    else               m_perr = 1'b1;
                end else begin
                    m_perr = 1'b1;
                    m_pfx.delete();
                end
            end else begin
                ext = (m_pfx.size() > 0) && (m_pfx[0] == 8'hE0);
                brk = (m_pfx.size() > 0) && (m_pfx[m_pfx.size()-1] == 8'hF0);
                k = key_of(code, ext);
                if (k >= 0) m_held[k] = !brk;
                m_pfx.delete();
            end
        end else if (tick) begin
            m_idle++;
            if (m_idle >= TIMEOUT) begin
                foreach (m_held[i]) m_held[i] = 1'b0;
                m_pfx.delete();
                m_idle = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic check_all(string ctx);
        check({ctx, ".key_held"},   {4'b0, key_held},   {4'b0, m_bitmap()});
        check({ctx, ".p1_move"},    {6'b0, p1_move},    {6'b0, m_p1});
        check({ctx, ".p2_move"},    {6'b0, p2_move},    {6'b0, m_p2});
        check({ctx, ".move_valid"}, {7'b0, move_valid}, {7'b0, m_mv});
        check({ctx, ".parse_err"},  {7'b0, parse_err},  {7'b0, m_perr});
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic step(string ctx, logic sv, logic [7:0] code, logic tick);
        scan_valid = sv;
        scan_code  = code;
        frame_tick = tick;
        model_step(sv, code, tick);
        @(posedge inclock);
        #1;
        scan_valid = 1'b0;
        frame_tick = 1'b0;
        check_all(ctx);
    endtask

    task automatic send(string ctx, logic [7:0] code);
        step(ctx, 1'b1, code, 1'b0);
    endtask

    task automatic tick(string ctx);
        step(ctx, 1'b0, 8'h00, 1'b1);
    endtask

    logic [7:0] pick_tbl [11] = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'h75, 8'h72,
                                  8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h00};

    initial begin
        logic [7:0] code;
        model_reset();
        repeat (3) @(posedge inclock);
        #1;
        check_all("reset");
        resetn = 1'b1;

        // W alone -> left paddle up
        send("w_make", 8'h1D);
        check("w_make.bitmap", {4'b0, key_held}, 8'h01);
        tick("w_tick");
        check("w_tick.p1_up", {6'b0, p1_move}, 8'h01);
        check("w_tick.p2_none", {6'b0, p2_move}, 8'h00);

        // W+S cancel, release W -> down
        send("s_make", 8'h1B);
        tick("ws_tick");
        check("ws_tick.p1_none", {6'b0, p1_move}, 8'h00);
        send("w_brk0", 8'hF0);
        send("w_brk1", 8'h1D);
        tick("s_tick");
        check("s_tick.p1_down", {6'b0, p1_move}, 8'h10 >> 3);
        send("s_brk0", 8'hF0);
        send("s_brk1", 8'h1B);

        // Extended Up, extended release, bare keypad 8 ignored
        send("up0", 8'hE0);
        send("up1", 8'h75);
        tick("up_tick");
        check("up_tick.p2_up", {6'b0, p2_move}, 8'h01);
        send("upb0", 8'hE0);
        send("upb1", 8'hF0);
        send("upb2", 8'h75);
        check("upb.bit2_clear", {7'b0, key_held[2]}, 8'h00);
        send("kp8", 8'h75);
        check("kp8.no_err", {7'b0, parse_err}, 8'h00);

        // E0 E0 72 -> one error, Down held; F0 F0 -> error, bitmap kept
        send("ee0", 8'hE0);
        send("ee1", 8'hE0);
        check("ee1.err", {7'b0, parse_err}, 8'h01);
        send("ee2", 8'h72);
        check("ee2.k_set", {7'b0, key_held[3]}, 8'h01);
        send("ff0", 8'hF0);
        send("ff1", 8'hF0);
        check("ff1.err", {7'b0, parse_err}, 8'h01);
        send("dnb0", 8'hE0);
        send("dnb1", 8'hF0);
        send("dnb2", 8'h72);

        // Watchdog: hold W, three silent ticks
        send("wd_w", 8'h1D);
        tick("wd_t1");
        tick("wd_t2");
        tick("wd_t3");
        check("wd_t3.p1_pre_clear", {6'b0, p1_move}, 8'h01);
        check("wd_t3.cleared", {4'b0, key_held}, 8'h00);
        tick("wd_t4");
        check("wd_t4.p1_none", {6'b0, p1_move}, 8'h00);

        // Byte coincident with third tick keeps the key
        send("wd2_w", 8'h1D);
        tick("wd2_t1");
        tick("wd2_t2");
        step("wd2_t3", 1'b1, 8'h1D, 1'b1);
        check("wd2_t3.kept", {4'b0, key_held}, 8'h01);
        tick("wd2_t4");
        tick("wd2_t5");
        tick("wd2_t6");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            code = pick_tbl[$urandom_range(0, 10)];
            if (code == 8'h00) code = 8'($urandom());
            step("rand", 1'($urandom_range(0, 1)), code, ($urandom_range(0, 3) == 0));
        end

        // Reset mid-sequence with W held and E0 pending
        send("rst_w", 8'h1D);
        send("rst_e0", 8'hE0);
        resetn = 1'b0;
        #2;
        model_reset();
        check("rst.key_held", {4'b0, key_held}, 8'h00);
        check("rst.p1", {6'b0, p1_move}, 8'h00);
        check("rst.p2", {6'b0, p2_move}, 8'h00);
        check("rst.mv", {7'b0, move_valid}, 8'h00);
        check("rst.perr", {7'b0, parse_err}, 8'h00);
        @(posedge inclock);
        #1;
        resetn = 1'b1;
        send("post_rst_72", 8'h72);
        check("post_rst_72.ignored", {4'b0, key_held}, 8'h00);
        tick("post_rst_tick");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
